// File: rtl/chained_zero_detector.sv
// rtl/chained_zero_detector.sv - two-stage zero / leading-zero detector over multi-beat operands
module chained_zero_detector #(
  parameter int REGISTER_LENGTH = 64,
  parameter int LANE_WIDTH      = 8,
  parameter int MAX_BEATS       = 4,
  localparam int LANES          = REGISTER_LENGTH / LANE_WIDTH,
  localparam int CNT_WIDTH      = $clog2(REGISTER_LENGTH * MAX_BEATS + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       valid_i,
  input  logic                       first_i,
  input  logic                       last_i,
  input  logic [REGISTER_LENGTH-1:0] in_i,
  input  logic                       stall_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic                       zero_o,
  output logic [LANES-1:0]           lane_zero_o,
  output logic [CNT_WIDTH-1:0]       lzc_o,
  output logic                       ovf_o,
  output logic                       err_o
);

  localparam int BW = $clog2(MAX_BEATS + 2);
  localparam logic [BW-1:0]      BEAT_SAT = BW'(MAX_BEATS + 1);
  localparam logic [BW-1:0]      BEAT_MAX = BW'(MAX_BEATS);
  localparam logic [CNT_WIDTH:0] LZC_SAT  = (CNT_WIDTH + 1)'(REGISTER_LENGTH * MAX_BEATS);

  typedef enum logic {IDLE, OPEN} state_t;

  function automatic logic [CNT_WIDTH-1:0] count_lz(input logic [REGISTER_LENGTH-1:0] w);
    logic [CNT_WIDTH-1:0] n;
    n = CNT_WIDTH'(REGISTER_LENGTH);
    for (int i = 0; i < REGISTER_LENGTH; i++)
      if (w[i]) n = CNT_WIDTH'(REGISTER_LENGTH - 1 - i);
    return n;
  endfunction

  assign ready_o = ~stall_i;

  logic [LANES-1:0] lane_zero_c;
  always_comb begin
    lane_zero_c = '0;
    for (int j = 0; j < LANES; j++)
      lane_zero_c[j] = ~|in_i[j*LANE_WIDTH +: LANE_WIDTH];
  end

  // Stage 1: capture the accepted beat and its lane mask
  logic                       s1_valid;
  logic                       s1_first;
  logic                       s1_last;
  logic [REGISTER_LENGTH-1:0] s1_data;
  logic [LANES-1:0]           s1_lane_zero;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid     <= 1'b0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      s1_data      <= '0;
      s1_lane_zero <= '0;
    end else if (!stall_i) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_first     <= first_i;
        s1_last      <= last_i;
        s1_data      <= in_i;
        s1_lane_zero <= lane_zero_c;
      end
    end
  end

  // Stage 2: chain accumulation
  state_t               state;
  logic                 acc_zero;
  logic                 acc_ovf;
  logic                 acc_err;
  logic [CNT_WIDTH-1:0] acc_lzc;
  logic [BW-1:0]        beat_cnt;

  logic                 word_zero;
  logic [CNT_WIDTH-1:0] word_lzc;
  logic [CNT_WIDTH:0]   lzc_sum;
  logic                 zero_n;
  logic                 ovf_n;
  logic                 err_n;
  logic [CNT_WIDTH-1:0] lzc_n;
  logic [BW-1:0]        cnt_n;

  always_comb begin
    word_zero = &s1_lane_zero;
    word_lzc  = count_lz(s1_data);
    lzc_sum   = {1'b0, acc_lzc} + {1'b0, word_lzc};
    zero_n    = word_zero;
    lzc_n     = word_lzc;
    cnt_n     = BW'(1);
    ovf_n     = 1'b0;
    err_n     = ~s1_first;
    // A first beat always restarts; a headless beat in IDLE starts a chain flagged as an error
    if (!s1_first && state == OPEN) begin
      cnt_n  = (beat_cnt == BEAT_SAT) ? beat_cnt : beat_cnt + BW'(1);
      ovf_n  = acc_ovf | (beat_cnt >= BEAT_MAX);
      err_n  = acc_err;
      zero_n = acc_zero & word_zero;
      if (acc_zero)
        lzc_n = (lzc_sum > LZC_SAT) ? LZC_SAT[CNT_WIDTH-1:0] : lzc_sum[CNT_WIDTH-1:0];
      else
        lzc_n = acc_lzc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      acc_zero    <= 1'b0;
      acc_ovf     <= 1'b0;
      acc_err     <= 1'b0;
      acc_lzc     <= '0;
      beat_cnt    <= '0;
      valid_o     <= 1'b0;
      zero_o      <= 1'b0;
      lane_zero_o <= '0;
      lzc_o       <= '0;
      ovf_o       <= 1'b0;
      err_o       <= 1'b0;
    end else if (!stall_i) begin
      valid_o <= 1'b0;
      if (s1_valid) begin
        acc_zero <= zero_n;
        acc_ovf  <= ovf_n;
        acc_err  <= err_n;
        acc_lzc  <= lzc_n;
        beat_cnt <= cnt_n;
        state    <= s1_last ? IDLE : OPEN;
        if (s1_last) begin
          valid_o     <= 1'b1;
          zero_o      <= zero_n;
          lane_zero_o <= s1_lane_zero;
          lzc_o       <= lzc_n;
          ovf_o       <= ovf_n;
          err_o       <= err_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_chained_zero_detector.sv
// tb/tb_chained_zero_detector.sv - directed self-checking bench for chained_zero_detector
module tb_chained_zero_detector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, first_i, last_i, stall_i;
  logic [63:0] in_i;
  logic        ready_o, valid_o, zero_o, ovf_o, err_o;
  logic [7:0]  lane_zero_o;
  logic [8:0]  lzc_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chained_zero_detector dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .valid_i     (valid_i),
    .first_i     (first_i),
    .last_i      (last_i),
    .in_i        (in_i),
    .stall_i     (stall_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .zero_o      (zero_o),
    .lane_zero_o (lane_zero_o),
    .lzc_o       (lzc_o),
    .ovf_o       (ovf_o),
    .err_o       (err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic f, input logic l, input logic [63:0] d);
    valid_i = 1'b1;
    first_i = f;
    last_i  = l;
    in_i    = d;
    @(negedge clk);
  endtask

  task automatic idle();
    valid_i = 1'b0;
    first_i = 1'b0;
    last_i  = 1'b0;
    in_i    = '0;
    @(negedge clk);
  endtask

  task automatic expect_result(input string tag, input logic zero, input logic [8:0] lzc,
                               input logic [7:0] lanes, input logic ovf, input logic err);
    check({tag, "_valid"}, valid_o, 1'b1);
    check({tag, "_zero"}, zero_o, zero);
    check({tag, "_lzc"}, lzc_o, lzc);
    check({tag, "_lanes"}, lane_zero_o, lanes);
    check({tag, "_ovf"}, ovf_o, ovf);
    check({tag, "_err"}, err_o, err);
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0; in_i = '0; stall_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid_o, 1'b0);
    check("rst_lzc", lzc_o, 9'd0);
    check("rst_lanes", lane_zero_o, 8'h00);
    check("rst_flags", {zero_o, ovf_o, err_o}, 3'b000);
    check("ready", ready_o, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    drive(1, 1, 64'h0); idle();
    expect_result("zero1", 1, 9'd64, 8'hFF, 0, 0);
    idle();
    check("zero1_pulse", valid_o, 1'b0);

    drive(1, 1, 64'h0000_0000_0001_0000); idle();
    expect_result("nz1", 0, 9'd47, 8'hFB, 0, 0);

    drive(1, 0, 64'h0); drive(0, 0, 64'h0); drive(0, 1, 64'h0080_0000_0000_0000);
    valid_i = 1'b0;
    check("b3_early", valid_o, 1'b0);
    @(negedge clk);
    expect_result("b3", 0, 9'd136, 8'hBF, 0, 0);
    idle();
    check("b3_pulse", valid_o, 1'b0);

    drive(1, 1, 64'h1); drive(1, 1, 64'h8000_0000_0000_0000);
    valid_i = 1'b0;
    expect_result("b2b_a", 0, 9'd63, 8'hFE, 0, 0);
    @(negedge clk);
    expect_result("b2b_b", 0, 9'd0, 8'h7F, 0, 0);
    idle();
    check("b2b_end", valid_o, 1'b0);

    drive(1, 1, 64'h0000_0000_0000_0100); idle();
    check("st_pre", valid_o, 1'b1);
    stall_i = 1'b1; valid_i = 1'b1; first_i = 1'b1; last_i = 1'b1; in_i = 64'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("st_ready", ready_o, 1'b0);
      expect_result("st_hold", 0, 9'd55, 8'hFD, 0, 0);
    end
    stall_i = 1'b0;
    idle();
    check("st_drop", valid_o, 1'b0);
    idle();
    check("st_noconsume", valid_o, 1'b0);

    drive(1, 0, 64'h0); repeat (2) drive(0, 0, 64'h0); drive(0, 1, 64'h0); idle();
    expect_result("b4", 1, 9'd256, 8'hFF, 0, 0);

    drive(1, 0, 64'h0); repeat (3) drive(0, 0, 64'h0); drive(0, 1, 64'h0); idle();
    expect_result("ovf", 1, 9'd256, 8'hFF, 1, 0);

    drive(1, 0, 64'h5); drive(0, 0, 64'h0);
    valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", valid_o, 1'b0);
    check("mrst_lzc", lzc_o, 9'd0);
    check("mrst_lanes", lane_zero_o, 8'h00);
    check("mrst_flags", {zero_o, ovf_o, err_o}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(0, 1, 64'h1); idle();
    expect_result("perr", 0, 9'd63, 8'hFE, 0, 1);

    drive(1, 1, 64'h0); idle();
    expect_result("perr_clr", 1, 9'd64, 8'hFF, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
